// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common data bus arbiter. ALU and LSB results each queue in a
//                small FIFO; a round-robin arbiter places one result per
//                cycle onto a registered broadcast bus toward ROB/RS/LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_rdy,
  input  logic              in_flush,
  input  logic              in_alu_enable,
  input  logic [ROB_W-1:0]  in_alu_reorder,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_alu_branch,
  output logic              out_alu_full,
  input  logic              in_lsb_enable,
  input  logic [ROB_W-1:0]  in_lsb_reorder,
  input  logic [DATA_W-1:0] in_lsb_result,
  input  logic              in_lsb_io_read,
  output logic              out_lsb_full,
  output logic              out_cdb_enable,
  output logic              out_cdb_src,
  output logic [ROB_W-1:0]  out_cdb_reorder,
  output logic [DATA_W-1:0] out_cdb_result,
  output logic [DATA_W-1:0] out_cdb_branch,
  output logic              out_cdb_io_read,
  output logic              out_overflow
);

  localparam int              c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // Result storage (no reset needed: validity is tracked by the counts)
  logic [ROB_W-1:0]  r_alu_tag_q [DEPTH];
  logic [DATA_W-1:0] r_alu_res_q [DEPTH];
  logic [DATA_W-1:0] r_alu_br_q  [DEPTH];
  logic [ROB_W-1:0]  r_lsb_tag_q [DEPTH];
  logic [DATA_W-1:0] r_lsb_res_q [DEPTH];
  logic              r_lsb_io_q  [DEPTH];

  logic [c_PTR_W-1:0] r_alu_rd, r_alu_wr, r_lsb_rd, r_lsb_wr;
  logic [c_CNT_W-1:0] r_alu_cnt, r_lsb_cnt;
  logic               r_last_lsb;   // 1 = last grant went to the LSB
  logic               r_overflow;

  logic              r_cdb_enable, r_cdb_src, r_cdb_io_read;
  logic [ROB_W-1:0]  r_cdb_reorder;
  logic [DATA_W-1:0] r_cdb_result, r_cdb_branch;

  logic w_alu_full, w_lsb_full, w_alu_has, w_lsb_has;
  logic w_alu_elig, w_lsb_elig, w_alu_gnt, w_lsb_gnt;
  logic w_alu_pop, w_lsb_pop, w_alu_push, w_lsb_push, w_active;
  logic [ROB_W-1:0]  w_alu_tag, w_lsb_tag;
  logic [DATA_W-1:0] w_alu_res, w_alu_br, w_lsb_res;
  logic              w_lsb_io;

  assign w_active   = in_rdy & ~in_flush;
  assign w_alu_full = (r_alu_cnt == c_FULL);
  assign w_lsb_full = (r_lsb_cnt == c_FULL);
  assign w_alu_has  = (r_alu_cnt != '0);
  assign w_lsb_has  = (r_lsb_cnt != '0);

  // Candidate per source: queued head first, otherwise the incoming result
  assign w_alu_tag = w_alu_has ? r_alu_tag_q[r_alu_rd] : in_alu_reorder;
  assign w_alu_res = w_alu_has ? r_alu_res_q[r_alu_rd] : in_alu_result;
  assign w_alu_br  = w_alu_has ? r_alu_br_q[r_alu_rd]  : in_alu_branch;
  assign w_lsb_tag = w_lsb_has ? r_lsb_tag_q[r_lsb_rd] : in_lsb_reorder;
  assign w_lsb_res = w_lsb_has ? r_lsb_res_q[r_lsb_rd] : in_lsb_result;
  assign w_lsb_io  = w_lsb_has ? r_lsb_io_q[r_lsb_rd]  : in_lsb_io_read;

  // Round robin: when both compete, the source that did not win last time wins
  assign w_alu_elig = w_alu_has | in_alu_enable;
  assign w_lsb_elig = w_lsb_has | in_lsb_enable;
  assign w_alu_gnt  = w_alu_elig & (~w_lsb_elig | r_last_lsb);
  assign w_lsb_gnt  = w_lsb_elig & ~w_alu_gnt;

  // A full FIFO drops the incoming result even if its head leaves this cycle
  assign w_alu_pop  = w_active & w_alu_gnt & w_alu_has;
  assign w_lsb_pop  = w_active & w_lsb_gnt & w_lsb_has;
  assign w_alu_push = w_active & in_alu_enable & ~w_alu_full & ~(w_alu_gnt & ~w_alu_has);
  assign w_lsb_push = w_active & in_lsb_enable & ~w_lsb_full & ~(w_lsb_gnt & ~w_lsb_has);

  // Write incoming results into the FIFO tails
  always_ff @(posedge in_clk) begin
    if (w_alu_push) begin
      r_alu_tag_q[r_alu_wr] <= in_alu_reorder;
      r_alu_res_q[r_alu_wr] <= in_alu_result;
      r_alu_br_q[r_alu_wr]  <= in_alu_branch;
    end
    if (w_lsb_push) begin
      r_lsb_tag_q[r_lsb_wr] <= in_lsb_reorder;
      r_lsb_res_q[r_lsb_wr] <= in_lsb_result;
      r_lsb_io_q[r_lsb_wr]  <= in_lsb_io_read;
    end
  end

  // FIFO pointers/counts, round-robin history and sticky overflow flag
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_alu_rd   <= '0;
      r_alu_wr   <= '0;
      r_alu_cnt  <= '0;
      r_lsb_rd   <= '0;
      r_lsb_wr   <= '0;
      r_lsb_cnt  <= '0;
      r_last_lsb <= 1'b1;
      r_overflow <= 1'b0;
    end else if (in_rdy) begin
      if ((in_alu_enable & w_alu_full) | (in_lsb_enable & w_lsb_full))
        r_overflow <= 1'b1;
      if (in_flush) begin
        r_alu_rd   <= '0;
        r_alu_wr   <= '0;
        r_alu_cnt  <= '0;
        r_lsb_rd   <= '0;
        r_lsb_wr   <= '0;
        r_lsb_cnt  <= '0;
        r_last_lsb <= 1'b1;
      end else begin
        if (w_alu_push) r_alu_wr <= r_alu_wr + 1'b1;
        if (w_alu_pop)  r_alu_rd <= r_alu_rd + 1'b1;
        if (w_lsb_push) r_lsb_wr <= r_lsb_wr + 1'b1;
        if (w_lsb_pop)  r_lsb_rd <= r_lsb_rd + 1'b1;
        if (w_alu_push & ~w_alu_pop)      r_alu_cnt <= r_alu_cnt + 1'b1;
        else if (w_alu_pop & ~w_alu_push) r_alu_cnt <= r_alu_cnt - 1'b1;
        if (w_lsb_push & ~w_lsb_pop)      r_lsb_cnt <= r_lsb_cnt + 1'b1;
        else if (w_lsb_pop & ~w_lsb_push) r_lsb_cnt <= r_lsb_cnt - 1'b1;
        if (w_alu_gnt | w_lsb_gnt) r_last_lsb <= w_lsb_gnt;
      end
    end
  end

  // Register the winner onto the broadcast bus; idle cycles only drop enable
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_cdb_enable  <= 1'b0;
      r_cdb_src     <= 1'b0;
      r_cdb_reorder <= '0;
      r_cdb_result  <= '0;
      r_cdb_branch  <= '0;
      r_cdb_io_read <= 1'b0;
    end else if (in_rdy) begin
      if (in_flush) begin
        r_cdb_enable <= 1'b0;
      end else if (w_alu_gnt) begin
        r_cdb_enable  <= 1'b1;
        r_cdb_src     <= 1'b0;
        r_cdb_reorder <= w_alu_tag;
        r_cdb_result  <= w_alu_res;
        r_cdb_branch  <= w_alu_br;
        r_cdb_io_read <= 1'b0;
      end else if (w_lsb_gnt) begin
        r_cdb_enable  <= 1'b1;
        r_cdb_src     <= 1'b1;
        r_cdb_reorder <= w_lsb_tag;
        r_cdb_result  <= w_lsb_res;
        r_cdb_branch  <= '0;
        r_cdb_io_read <= w_lsb_io;
      end else begin
        r_cdb_enable <= 1'b0;
      end
    end
  end

  assign out_alu_full    = w_alu_full;
  assign out_lsb_full    = w_lsb_full;
  assign out_cdb_enable  = r_cdb_enable;
  assign out_cdb_src     = r_cdb_src;
  assign out_cdb_reorder = r_cdb_reorder;
  assign out_cdb_result  = r_cdb_result;
  assign out_cdb_branch  = r_cdb_branch;
  assign out_cdb_io_read = r_cdb_io_read;
  assign out_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed self-checking bench for cdb_arbiter (DEPTH = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        in_clk = 1'b0;
  logic        in_rst_n, in_rdy, in_flush;
  logic        in_alu_enable, in_lsb_enable, in_lsb_io_read;
  logic [3:0]  in_alu_reorder, in_lsb_reorder;
  logic [31:0] in_alu_result, in_alu_branch, in_lsb_result;
  logic        out_alu_full, out_lsb_full, out_cdb_enable, out_cdb_src;
  logic        out_cdb_io_read, out_overflow;
  logic [3:0]  out_cdb_reorder;
  logic [31:0] out_cdb_result, out_cdb_branch;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  cdb_arbiter #(.DEPTH(2), .ROB_W(4), .DATA_W(32)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_rdy(in_rdy), .in_flush(in_flush),
    .in_alu_enable(in_alu_enable), .in_alu_reorder(in_alu_reorder),
    .in_alu_result(in_alu_result), .in_alu_branch(in_alu_branch),
    .out_alu_full(out_alu_full),
    .in_lsb_enable(in_lsb_enable), .in_lsb_reorder(in_lsb_reorder),
    .in_lsb_result(in_lsb_result), .in_lsb_io_read(in_lsb_io_read),
    .out_lsb_full(out_lsb_full),
    .out_cdb_enable(out_cdb_enable), .out_cdb_src(out_cdb_src),
    .out_cdb_reorder(out_cdb_reorder), .out_cdb_result(out_cdb_result),
    .out_cdb_branch(out_cdb_branch), .out_cdb_io_read(out_cdb_io_read),
    .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_alu(input int k);
    in_alu_enable  = 1'b1;
    in_alu_reorder = 4'(k);
    in_alu_result  = 32'(32'hA0 + k);
    in_alu_branch  = 32'(32'hB0 + k);
  endtask

  task automatic set_lsb(input int t, input logic io);
    in_lsb_enable  = 1'b1;
    in_lsb_reorder = 4'(t);
    in_lsb_result  = 32'(32'hC0 + t);
    in_lsb_io_read = io;
  endtask

  task automatic clr_in();
    in_alu_enable = 1'b0;
    in_lsb_enable = 1'b0;
  endtask

  task automatic exp_alu(input string nm, input int k);
    chk({nm, ".en"},  64'(out_cdb_enable), 64'd1);
    chk({nm, ".src"}, 64'(out_cdb_src), 64'd0);
    chk({nm, ".tag"}, 64'(out_cdb_reorder), 64'(k));
    chk({nm, ".res"}, 64'(out_cdb_result), 64'(32'hA0 + k));
    chk({nm, ".br"},  64'(out_cdb_branch), 64'(32'hB0 + k));
    chk({nm, ".io"},  64'(out_cdb_io_read), 64'd0);
  endtask

  task automatic exp_lsb(input string nm, input int t, input logic io);
    chk({nm, ".en"},  64'(out_cdb_enable), 64'd1);
    chk({nm, ".src"}, 64'(out_cdb_src), 64'd1);
    chk({nm, ".tag"}, 64'(out_cdb_reorder), 64'(t));
    chk({nm, ".res"}, 64'(out_cdb_result), 64'(32'hC0 + t));
    chk({nm, ".br"},  64'(out_cdb_branch), 64'd0);
    chk({nm, ".io"},  64'(out_cdb_io_read), 64'(io));
  endtask

  task automatic exp_idle(input string nm);
    chk({nm, ".en"}, 64'(out_cdb_enable), 64'd0);
  endtask

  task automatic exp_full(input string nm, input logic af, input logic lf);
    chk({nm, ".alu_full"}, 64'(out_alu_full), 64'(af));
    chk({nm, ".lsb_full"}, 64'(out_lsb_full), 64'(lf));
  endtask

  task automatic pulse_reset();
    in_rst_n = 1'b0;
    #2;
    in_rst_n = 1'b1;
  endtask

  // Fairness test vectors: per-cycle enables and expected broadcasts/full flags
  logic f_ae [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic f_le [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic f_src [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   f_idx [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 5};
  logic f_af [9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic f_lf [9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int ak;
    int lk;
    in_rst_n = 1'b0; in_rdy = 1'b1; in_flush = 1'b0;
    in_alu_enable = 1'b0; in_alu_reorder = '0; in_alu_result = '0; in_alu_branch = '0;
    in_lsb_enable = 1'b0; in_lsb_reorder = '0; in_lsb_result = '0; in_lsb_io_read = 1'b0;

    // Reset state
    #3;
    chk("rst.en", 64'(out_cdb_enable), 64'd0);
    chk("rst.tag", 64'(out_cdb_reorder), 64'd0);
    chk("rst.res", 64'(out_cdb_result), 64'd0);
    chk("rst.ovf", 64'(out_overflow), 64'd0);
    exp_full("rst", 1'b0, 1'b0);
    #9 in_rst_n = 1'b1;
    tick();

    // 1: ALU alone, tag 3 value 0x11, visible one cycle only
    in_alu_enable = 1'b1; in_alu_reorder = 4'd3; in_alu_result = 32'h11; in_alu_branch = 32'h100;
    tick();
    chk("t1.en", 64'(out_cdb_enable), 64'd1);
    chk("t1.src", 64'(out_cdb_src), 64'd0);
    chk("t1.tag", 64'(out_cdb_reorder), 64'd3);
    chk("t1.res", 64'(out_cdb_result), 64'h11);
    chk("t1.br", 64'(out_cdb_branch), 64'h100);
    clr_in();
    tick();
    exp_idle("t1.after");
    chk("t1.hold_tag", 64'(out_cdb_reorder), 64'd3);

    // 2: simultaneous ALU tag 1 and LSB tag 2 after reset -> ALU first
    pulse_reset();
    set_alu(1); set_lsb(2, 1'b1);
    tick();
    exp_alu("t2.a", 1);
    exp_full("t2.a", 1'b0, 1'b0);
    clr_in();
    tick();
    exp_lsb("t2.l", 2, 1'b1);
    tick();
    exp_idle("t2.idle");

    // 3: both producers busy for 6 cycles (honouring full) -> alternation
    ak = 1; lk = 1;
    for (int i = 0; i < 9; i++) begin
      clr_in();
      if (i < 6 && f_ae[i]) begin set_alu(ak); ak++; end
      if (i < 6 && f_le[i]) begin set_lsb(8 + lk, 1'(lk)); lk++; end
      tick();
      if (f_src[i]) exp_lsb($sformatf("t3.c%0d", i), 8 + f_idx[i], 1'(f_idx[i]));
      else          exp_alu($sformatf("t3.c%0d", i), f_idx[i]);
      exp_full($sformatf("t3.c%0d", i), f_af[i], f_lf[i]);
    end
    clr_in();
    tick();
    exp_idle("t3.idle");

    // 4: fill LSB FIFO, then enable while full -> dropped, sticky overflow
    pulse_reset();
    set_alu(1); set_lsb(5, 1'b0);
    tick();
    exp_alu("t4.e1", 1);
    set_alu(2); set_lsb(6, 1'b0);
    tick();
    exp_lsb("t4.e2", 5, 1'b0);
    set_alu(3); set_lsb(7, 1'b0);
    tick();
    exp_alu("t4.e3", 2);
    exp_full("t4.e3", 1'b0, 1'b1);
    clr_in(); set_lsb(15, 1'b1);
    tick();
    exp_lsb("t4.e4", 6, 1'b0);
    chk("t4.ovf", 64'(out_overflow), 64'd1);
    exp_full("t4.e4", 1'b0, 1'b0);
    clr_in();
    tick();
    exp_alu("t4.e5", 3);
    tick();
    exp_lsb("t4.e6", 7, 1'b0);
    tick();
    exp_idle("t4.e7");
    chk("t4.ovf_sticky", 64'(out_overflow), 64'd1);

    // 5: queue entries on both sides, flush with new results arriving
    set_alu(1); set_lsb(9, 1'b0);
    tick();
    exp_alu("t5.a", 1);
    clr_in(); set_alu(2);
    tick();
    exp_lsb("t5.b", 9, 1'b0);
    set_alu(3); set_lsb(10, 1'b0);
    tick();
    exp_alu("t5.c", 2);
    set_alu(4); set_lsb(11, 1'b1); in_flush = 1'b1;
    tick();
    exp_idle("t5.flush");
    exp_full("t5.flush", 1'b0, 1'b0);
    chk("t5.ovf", 64'(out_overflow), 64'd1);
    in_flush = 1'b0; clr_in();
    tick();
    exp_idle("t5.e");
    set_alu(5); set_lsb(12, 1'b0);
    tick();
    exp_alu("t5.f", 5);
    clr_in();
    tick();
    exp_lsb("t5.g", 12, 1'b0);
    tick();
    exp_idle("t5.h");

    // 6a: freeze with queued data, then resume in order
    set_alu(1); set_lsb(1, 1'b1);
    tick();
    exp_alu("t6.pre", 1);
    in_rdy = 1'b0; set_alu(2); set_lsb(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_alu($sformatf("t6.frz%0d", i), 1);
      exp_full($sformatf("t6.frz%0d", i), 1'b0, 1'b0);
    end
    in_rdy = 1'b1; clr_in();
    tick();
    exp_lsb("t6.resume", 1, 1'b1);
    tick();
    exp_idle("t6.nodrop");

    // 6b: asynchronous reset with entries queued
    set_alu(3); set_lsb(3, 1'b1);
    tick();
    exp_alu("t6.q1", 3);
    set_alu(4); set_lsb(4, 1'b0);
    tick();
    exp_lsb("t6.q2", 3, 1'b1);
    clr_in();
    #2 in_rst_n = 1'b0;
    #1;
    chk("t6.rst.en", 64'(out_cdb_enable), 64'd0);
    chk("t6.rst.src", 64'(out_cdb_src), 64'd0);
    chk("t6.rst.tag", 64'(out_cdb_reorder), 64'd0);
    chk("t6.rst.res", 64'(out_cdb_result), 64'd0);
    chk("t6.rst.io", 64'(out_cdb_io_read), 64'd0);
    chk("t6.rst.ovf", 64'(out_overflow), 64'd0);
    #1 in_rst_n = 1'b1;
    tick();
    exp_idle("t6.post1");
    tick();
    exp_idle("t6.post2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
